// File: rtl/maze_progress.sv
// Round controller for the maze game: gates player motion, counts moves, runs the frame
// timer, detects the goal and queues letter-cell picks for the hangman guess logic.
module maze_progress #(
  parameter int size_y     = 20,
  parameter int size_x     = 40,
  parameter int GOAL_X     = 38,
  parameter int GOAL_Y     = 18,
  parameter int TIME_LIMIT = 3600
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            start,
  input  logic                            frame_tick,
  input  logic                            lose_req,
  input  logic [5:0]                      ball_x,
  input  logic [5:0]                      ball_y,
  input  logic [0:size_x-1][size_y-1:0]   letter_map,
  output logic                            game_ready,
  output logic                            won,
  output logic                            lost,
  output logic [9:0]                      moves,
  output logic [15:0]                     frames_left,
  output logic                            pick_valid,
  output logic [5:0]                      pick_x,
  output logic [5:0]                      pick_y,
  input  logic                            pick_ready
);

  localparam int XW = $clog2(size_x);
  localparam int YW = $clog2(size_y);
  localparam logic [5:0]  X_LIM = 6'(size_x);
  localparam logic [5:0]  Y_LIM = 6'(size_y);
  localparam logic [15:0] T_LIM = 16'(TIME_LIMIT);
  localparam logic [9:0]  MOVES_MAX = 10'd1023;

  typedef enum logic [1:0] {IDLE, PLAY, WON, LOST} state_t;
  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
  } cell_t;

  state_t state;
  cell_t  prev;
  cell_t  slot [2];
  logic   rd_ptr, wr_ptr;
  logic [1:0] count;
  logic [size_x-1:0][size_y-1:0] collected;

  cell_t         cur;
  logic          in_play, changed, in_range, letter_hit, goal_hit;
  logic          pop, push, full, tick_expire;
  logic [XW-1:0] xi;
  logic [YW-1:0] yi;

  assign cur      = '{x: ball_x, y: ball_y};
  assign in_play  = (state == PLAY);
  assign changed  = in_play && (cur != prev);
  assign in_range = (ball_x < X_LIM) && (ball_y < Y_LIM);
  assign xi       = ball_x[XW-1:0];
  assign yi       = ball_y[YW-1:0];

  // The map's first dimension is the column, so a cell (x,y) is letter_map[x][y].
  assign letter_hit  = in_range && letter_map[xi][yi] && !collected[xi][yi];
  assign goal_hit    = changed && (ball_x == 6'(GOAL_X)) && (ball_y == 6'(GOAL_Y));
  assign full        = (count == 2'd2);
  assign pop         = pick_valid && pick_ready;
  assign push        = changed && letter_hit && (!full || pop);
  assign tick_expire = frame_tick && (frames_left == 16'd1);

  assign game_ready = (state == PLAY);
  assign won        = (state == WON);
  assign lost       = (state == LOST);
  assign pick_valid = (count != 2'd0);
  assign pick_x     = slot[rd_ptr].x;
  assign pick_y     = slot[rd_ptr].y;

  // NOTE: every register here updates with <= so all next-state terms read the values
  // from before this edge; mixing in = would make results depend on statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      moves       <= '0;
      frames_left <= T_LIM;
      prev        <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      collected   <= '0;
      // NOTE: the two queue slots are reset only so pick_x/pick_y read 0 out of reset;
      // a deep storage array would normally be left unreset and guarded by its count.
      slot[0]     <= '0;
      slot[1]     <= '0;
    end else if (start) begin
      state       <= PLAY;
      moves       <= '0;
      frames_left <= T_LIM;
      prev        <= cur;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      collected   <= '0;
    end else begin
      if (pop) rd_ptr <= ~rd_ptr;
      if (push) begin
        slot[wr_ptr]      <= cur;
        wr_ptr            <= ~wr_ptr;
        collected[xi][yi] <= 1'b1;
      end
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;

      if (in_play) begin
        prev <= cur;
        if (changed && moves != MOVES_MAX) moves <= moves + 10'd1;
        if (frame_tick && frames_left != 16'd0) frames_left <= frames_left - 16'd1;
        // Reaching the goal outranks a simultaneous timeout or lose request.
        if (goal_hit)                     state <= WON;
        else if (tick_expire || lose_req) state <= LOST;
      end
    end
  end

endmodule
